// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM select/mux path (demux receive side and mux-side framer).
//   tdm_state_e : frame alignment state, StHunt (searching for sync) / StLocked (aligned)
//   CH_DEFAULT, W_DEFAULT : default channel count and word width
//   SLOT_W, BIT_W : slot and bit counter widths for the default geometry
package tdm_demux_pkg;

  localparam int unsigned CH_DEFAULT = 4;
  localparam int unsigned W_DEFAULT  = 8;
  localparam int unsigned SLOT_W     = $clog2(CH_DEFAULT);
  localparam int unsigned BIT_W      = $clog2(W_DEFAULT);

  typedef enum logic [0:0] {
    StHunt   = 1'b0,
    StLocked = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_demux.sv
// TDM demultiplexer: splits one channel-interleaved serial stream (slot k = channel k) back into
// CH parallel W-bit words. Locks on frame_sync at slot 0, presents a full word set with a
// one-cycle out_valid strobe and flags alignment violations with a one-cycle sync_err strobe.
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset
//   din        : serial bit of current slot
//   din_valid  : qualifies din/frame_sync; nothing moves while low
//   frame_sync : marks the slot-0 bit of each frame
//   out_data   : channel k word at out_data[k*W +: W]
//   out_valid  : one-cycle strobe, out_data updated
//   locked     : frame alignment held
//   slot       : slot index expected for the next accepted bit
//   sync_err   : one-cycle strobe, alignment violation
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int unsigned CH = CH_DEFAULT,
  parameter int unsigned W  = W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    frame_sync,
  output logic [CH*W-1:0]         out_data,
  output logic                    out_valid,
  output logic                    locked,
  output logic [$clog2(CH)-1:0]   slot,
  output logic                    sync_err
);

  localparam int unsigned SlotW = $clog2(CH);
  localparam int unsigned BitW  = $clog2(W);

  localparam logic [SlotW-1:0] SlotLast = SlotW'(CH - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(W - 1);

  tdm_state_e       state_q, state_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [W-1:0]     sh_q [CH];
  logic [W-1:0]     sh_d [CH];
  logic [CH*W-1:0]  out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sync_err_q, sync_err_d;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          if (frame_sync) begin
            // Sync bit opens a fresh word set as channel 0's first bit.
            state_d   = StLocked;
            for (int k = 0; k < CH; k++) sh_d[k] = '0;
            sh_d[0]   = {{(W-1){1'b0}}, din};
            slot_d    = SlotW'(1);
            bit_cnt_d = '0;
          end
        end

        StLocked: begin
          if (frame_sync && (slot_q != '0)) begin
            // Early sync: realign on this bit, dropping the partial set.
            sync_err_d = 1'b1;
            for (int k = 0; k < CH; k++) sh_d[k] = '0;
            sh_d[0]    = {{(W-1){1'b0}}, din};
            slot_d     = SlotW'(1);
            bit_cnt_d  = '0;
          end else if (!frame_sync && (slot_q == '0)) begin
            // Missing sync: alignment lost, bit dropped.
            sync_err_d = 1'b1;
            state_d    = StHunt;
            for (int k = 0; k < CH; k++) sh_d[k] = '0;
            slot_d     = '0;
            bit_cnt_d  = '0;
          end else begin
            sh_d[slot_q] = {sh_q[slot_q][W-2:0], din};
            if (slot_q == SlotLast) begin
              slot_d = '0;
              if (bit_cnt_q == BitLast) begin
                bit_cnt_d   = '0;
                out_valid_d = 1'b1;
                // Uses sh_d so the final bit of the last channel is included.
                for (int k = 0; k < CH; k++) out_data_d[k*W +: W] = sh_d[k];
              end else begin
                bit_cnt_d = bit_cnt_q + BitW'(1);
              end
            end else begin
              slot_d = slot_q + SlotW'(1);
            end
          end
        end

        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      slot_q      <= '0;
      bit_cnt_q   <= '0;
      for (int k = 0; k < CH; k++) sh_q[k] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      bit_cnt_q   <= bit_cnt_d;
      for (int k = 0; k < CH; k++) sh_q[k] <= sh_d[k];
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign slot      = slot_q;
  assign locked    = (state_q == StLocked);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (CH=4, W=8): a per-cycle vector table for the framing FSM,
// then hand-written word-set sequences for nominal, hunt, gapped, early/missing sync and reset.
module tb_tdm_demux;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          din;
  logic          din_valid;
  logic          frame_sync;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          locked;
  logic [1:0]    slot;
  logic          sync_err;

  always #5 clk = ~clk;

  tdm_demux #(
    .CH (CH),
    .W  (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .locked     (locked),
    .slot       (slot),
    .sync_err   (sync_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ov_cnt   = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  // Strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid) ov_cnt++;
    if (sync_err) err_cnt++;
    if (out_valid && sync_err) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic bit_in(input logic v, input logic fs, input logic d);
    din_valid  = v;
    frame_sync = fs;
    din        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_data"}, out_data, 32'h0);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
    check({tag, "_locked"}, {31'b0, locked}, 32'h0);
    check({tag, "_slot"}, {30'b0, slot}, 32'h0);
    check({tag, "_sync_err"}, {31'b0, sync_err}, 32'h0);
  endtask

  // Send W frames carrying one word per channel, MSB-first, sync on every slot 0.
  // With gaps, an invalid cycle (with noisy sync/data) follows every bit but the last.
  task automatic send_set(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                          input logic [7:0] w3, input bit gaps);
    logic [7:0] w [CH];
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    w[3] = w3;
    for (int f = 0; f < W; f++) begin
      for (int k = 0; k < CH; k++) begin
        bit_in(1'b1, (k == 0), w[k][W-1-f]);
        if (gaps && !((f == W - 1) && (k == CH - 1))) begin
          bit_in(1'b0, 1'b1, 1'b1);
          check("gap_slot_hold", {30'b0, slot}, 32'((k + 1) % CH));
        end
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic run_nominal(input string tag, input bit gaps);
    int ov_base;
    int err_base;
    ov_base  = ov_cnt;
    err_base = err_cnt;
    send_set(8'hA5, 8'h3C, 8'hF0, 8'h01, gaps);
    check({tag, "_out_valid_hi"}, {31'b0, out_valid}, 32'h1);
    check({tag, "_out_data"}, out_data, 32'h01F03CA5);
    check({tag, "_locked"}, {31'b0, locked}, 32'h1);
    bit_in(1'b0, 1'b0, 1'b0);
    check({tag, "_out_valid_lo"}, {31'b0, out_valid}, 32'h0);
    check({tag, "_out_data_hold"}, out_data, 32'h01F03CA5);
    check({tag, "_ov_count"}, 32'(ov_cnt - ov_base), 32'h1);
    check({tag, "_err_count"}, 32'(err_cnt - err_base), 32'h0);
  endtask

  typedef struct {
    logic       v;
    logic       fs;
    logic       d;
    logic [1:0] exp_slot;
    logic       exp_locked;
    logic       exp_err;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int ov_base;
    int err_base;

    rst        = 1'b1;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;

    // Per-cycle framing vectors from reset: hunt, lock, gap, wrap, early and missing sync.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0};

    // 1: reset
    do_reset();
    check_idle("reset");

    for (int i = 0; i < 15; i++) begin
      bit_in(tbl[i].v, tbl[i].fs, tbl[i].d);
      check($sformatf("vec%0d_slot", i), {30'b0, slot}, {30'b0, tbl[i].exp_slot});
      check($sformatf("vec%0d_locked", i), {31'b0, locked}, {31'b0, tbl[i].exp_locked});
      check($sformatf("vec%0d_sync_err", i), {31'b0, sync_err}, {31'b0, tbl[i].exp_err});
      check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, 32'h0);
    end

    // 2: nominal
    do_reset();
    run_nominal("nominal", 1'b0);

    // 3: unsynced bits ahead of the stream are ignored
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b1, 1'b0, i[0]);
      check("hunt_locked", {31'b0, locked}, 32'h0);
      check("hunt_slot", {30'b0, slot}, 32'h0);
    end
    run_nominal("hunt", 1'b0);

    // 4: din_valid low every other cycle
    do_reset();
    run_nominal("gaps", 1'b1);

    // 5: early sync at slot 2 of frame 3, then a full set starting with that sync bit
    ov_base  = ov_cnt;
    err_base = err_cnt;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < CH; k++) bit_in(1'b1, (k == 0), 1'b1);
    bit_in(1'b1, 1'b1, 1'b0);
    bit_in(1'b1, 1'b0, 1'b1);
    check("early_pre_slot", {30'b0, slot}, 32'h2);
    send_set(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    check("early_out_valid", {31'b0, out_valid}, 32'h1);
    check("early_out_data", out_data, 32'h44332211);
    check("early_locked", {31'b0, locked}, 32'h1);
    bit_in(1'b0, 1'b0, 1'b0);
    check("early_err_count", 32'(err_cnt - err_base), 32'h1);
    check("early_ov_count", 32'(ov_cnt - ov_base), 32'h1);

    // 6: missing sync on frame 4 slot 0, then reset mid-word
    ov_base  = ov_cnt;
    err_base = err_cnt;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < CH; k++) bit_in(1'b1, (k == 0), f[0] ^ k[0]);
    bit_in(1'b1, 1'b0, 1'b1);
    check("miss_sync_err", {31'b0, sync_err}, 32'h1);
    check("miss_locked", {31'b0, locked}, 32'h0);
    check("miss_slot", {30'b0, slot}, 32'h0);
    check("miss_out_valid", {31'b0, out_valid}, 32'h0);
    bit_in(1'b1, 1'b1, 1'b1);
    bit_in(1'b1, 1'b0, 1'b0);
    bit_in(1'b1, 1'b0, 1'b1);
    check("relock_slot", {30'b0, slot}, 32'h3);
    check("relock_locked", {31'b0, locked}, 32'h1);
    rst       = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("midword_rst");
    check("miss_err_count", 32'(err_cnt - err_base), 32'h1);
    check("miss_ov_count", 32'(ov_cnt - ov_base), 32'h0);
    run_nominal("after_rst", 1'b0);

    check("strobes_exclusive", 32'(both_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
